// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: EX forward selects and MDU sequencer states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_sequencer.sv
// MDU occupancy tracker: one BUSY period of MUL_LAT or DIV_LAT cycles per started op.
//
// state    | meaning
// MDU_IDLE | no multiply/divide in flight; a start from EX is accepted
// MDU_BUSY | op in flight; r_count holds the remaining BUSY cycles minus one
module mdu_sequencer
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CW      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic MduStartE,
    input  logic MduDivE,
    input  logic FlushAll,
    output logic MduBusy
);

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    mdu_state_t    r_state;
    mdu_state_t    w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MDU_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // A start squashed by a redirect never reaches the MDU.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            MDU_IDLE: begin
                if (MduStartE && !FlushAll) begin
                    w_state_nxt = MDU_BUSY;
                    w_count_nxt = MduDivE ? DIV_LOAD : MUL_LOAD;
                end
            end
            MDU_BUSY: begin
                if (r_count == '0) begin
                    w_state_nxt = MDU_IDLE;
                end else begin
                    w_count_nxt = r_count - ONE;
                end
            end
            default: w_state_nxt = MDU_IDLE;
        endcase
    end

    assign MduBusy = (r_state == MDU_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: per-register countdown scoreboard, MDU-aware stalls,
// redirect flushes with undo of the squashed issue, and EX/ID forward selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int RW      = 5,
    parameter int MEM_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CW      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] RsD,
    input  logic [RW-1:0] RtD,
    input  logic          UseRsD,
    input  logic          UseRtD,
    input  logic          BranchD,
    input  logic          RegWriteD,
    input  logic [RW-1:0] WriteRegD,
    input  logic          MemReadD,
    input  logic          MduOpD,
    input  logic          HiLoReadD,
    input  logic          MduStartE,
    input  logic          MduDivE,
    input  logic [RW-1:0] RsE,
    input  logic [RW-1:0] RtE,
    input  logic          RegWriteM,
    input  logic [RW-1:0] WriteRegM,
    input  logic          RegWriteW,
    input  logic [RW-1:0] WriteRegW,
    input  logic          FlushAll,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushD,
    output logic          FlushE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          ForwardAD,
    output logic          ForwardBD,
    output logic          MduBusy
);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] LOAD_CNT = CW'(1 + MEM_LAT);
    localparam logic [CW-1:0] ALU_CNT  = CW'(1);

    logic [CW-1:0] r_cnt [NREG];
    logic          r_last_vld;
    logic [RW-1:0] r_last_reg;
    logic [CW-1:0] r_last_cnt;

    logic [CW-1:0] w_cnt_rs;
    logic [CW-1:0] w_cnt_rt;
    logic          w_stall_rs;
    logic          w_stall_rt;
    logic          w_mdustall;
    logic          w_lstall;
    logic          w_issue;
    logic          w_alloc;
    logic          w_restore;
    logic [CW-1:0] w_alloc_cnt;
    logic          w_m_fwd_ok;
    logic          w_w_fwd_ok;

    mdu_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CW      (CW)
    ) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .MduStartE (MduStartE),
        .MduDivE   (MduDivE),
        .FlushAll  (FlushAll),
        .MduBusy   (MduBusy)
    );

    // ID comparators need the value one cycle earlier than EX forwarding can supply it.
    assign w_cnt_rs   = r_cnt[RsD];
    assign w_cnt_rt   = r_cnt[RtD];
    assign w_stall_rs = UseRsD && (RsD != '0) &&
                        (BranchD ? (w_cnt_rs != '0) : (w_cnt_rs > ONE));
    assign w_stall_rt = UseRtD && (RtD != '0) &&
                        (BranchD ? (w_cnt_rt != '0) : (w_cnt_rt > ONE));
    assign w_mdustall = MduBusy && (MduOpD || HiLoReadD);
    assign w_lstall   = w_stall_rs || w_stall_rt || w_mdustall;

    assign w_issue     = !w_lstall && !FlushAll;
    assign w_alloc     = w_issue && RegWriteD && (WriteRegD != '0);
    assign w_restore   = FlushAll && r_last_vld;
    assign w_alloc_cnt = MemReadD ? LOAD_CNT : ALU_CNT;

    // Allocation beats decrement; the undo of a squashed issue restores its captured prior count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_last_vld <= 1'b0;
            r_last_reg <= '0;
            r_last_cnt <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (w_alloc && (WriteRegD == RW'(i))) begin
                    r_cnt[i] <= w_alloc_cnt;
                end else if (w_restore && (r_last_reg == RW'(i))) begin
                    r_cnt[i] <= r_last_cnt;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - ONE;
                end
            end
            r_last_vld <= w_alloc;
            r_last_reg <= WriteRegD;
            r_last_cnt <= r_cnt[WriteRegD];
        end
    end

    assign StallF = w_lstall;
    assign StallD = w_lstall;
    assign FlushD = FlushAll;
    assign FlushE = w_lstall || FlushAll;

    assign w_m_fwd_ok = RegWriteM && (WriteRegM != '0);
    assign w_w_fwd_ok = RegWriteW && (WriteRegW != '0);

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (w_m_fwd_ok && (WriteRegM == RsE)) begin
            ForwardAE = FWD_MEM;
        end else if (w_w_fwd_ok && (WriteRegW == RsE)) begin
            ForwardAE = FWD_WB;
        end
        if (w_m_fwd_ok && (WriteRegM == RtE)) begin
            ForwardBE = FWD_MEM;
        end else if (w_w_fwd_ok && (WriteRegW == RtE)) begin
            ForwardBE = FWD_WB;
        end
    end

    // WB into ID is covered by the write-first register file, so ID forwards from MEM only.
    assign ForwardAD = w_m_fwd_ok && (WriteRegM == RsD);
    assign ForwardBD = w_m_fwd_ok && (WriteRegM == RtD);

endmodule
